// File: rtl/bubble_sort_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bubble_sort_pkg
//  Description : Shared types and helpers for the sequential bubble sorter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bubble_sort_pkg;

    // Controller states of the sequential sorter
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of compare cycles of a full (no early exit) sort
    function automatic int n_compares(input int dim);
        return (dim * (dim - 1)) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bubble_sort_seq_compare_swap.sv
`default_nettype none
// ============================================================================
//  Module      : compare_swap
//  Description : Combinational compare-exchange cell. lo/hi are the ordered
//                pair; swapped flags a strictly greater than b (unsigned),
//                so equal inputs pass straight through.
//  Revision    : 1.0 - initial release
// ============================================================================
module compare_swap #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             swapped
);

    assign swapped = (a > b);
    assign lo      = swapped ? b : a;
    assign hi      = swapped ? a : b;

endmodule
`default_nettype wire

// File: rtl/bubble_sort_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bubble_sort_seq
//  Description : Sequential in-place bubble sorter. Loads one packed array via
//                valid/ready, performs one compare-exchange per clock on a
//                shared compare_swap cell, then presents the ascending result
//                via valid/ready.
//  Options     : define BUBBLE_SORT_SEQ_EARLY_EXIT_EN to finish after the
//                first pass that performs no swap.
//  Revision    : 1.0 - initial release
// ============================================================================
module bubble_sort_seq #(
    parameter int DIM   = 4,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DIM*WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DIM*WIDTH-1:0] out_data,
    output logic                 busy
);
    import bubble_sort_pkg::*;

    localparam int            CW     = (DIM > 2) ? $clog2(DIM) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DIM - 2);

    state_e                         state_q, state_d;
    logic [DIM-1:0][WIDTH-1:0]      mem_q, mem_d;
    logic [CW-1:0]                  p_q, p_d;
    logic [CW-1:0]                  j_q, j_d;
`ifdef BUBBLE_SORT_SEQ_EARLY_EXIT_EN
    logic                           swf_q, swf_d;
    logic                           w_pass_swapped;
`endif

    logic [CW-1:0]    w_j1;
    logic [CW-1:0]    w_limit;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;
    logic             w_swapped;

    // Neighbour index and last compare index of the current pass, both at counter width
    assign w_j1    = j_q + CW'(1);
    assign w_limit = C_LAST - p_q;

    compare_swap #(
        .WIDTH   (WIDTH)
    ) u_cmp (
        .a       (mem_q[j_q]),
        .b       (mem_q[w_j1]),
        .lo      (w_lo),
        .hi      (w_hi),
        .swapped (w_swapped)
    );

`ifdef BUBBLE_SORT_SEQ_EARLY_EXIT_EN
    assign w_pass_swapped = swf_q | w_swapped;
`endif

    // Next-state, register-file and counter update for load / compare / hand-off
    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        p_d     = p_q;
        j_d     = j_q;
`ifdef BUBBLE_SORT_SEQ_EARLY_EXIT_EN
        swf_d   = swf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mem_d   = in_data;
                    p_d     = '0;
                    j_d     = '0;
`ifdef BUBBLE_SORT_SEQ_EARLY_EXIT_EN
                    swf_d   = 1'b0;
`endif
                    state_d = SORT;
                end
            end
            SORT: begin
                if (w_swapped) begin
                    mem_d[j_q] = w_lo;
                    mem_d[w_j1] = w_hi;
                end
                if (j_q < w_limit) begin
                    j_d = w_j1;
`ifdef BUBBLE_SORT_SEQ_EARLY_EXIT_EN
                    swf_d = w_pass_swapped;
`endif
                end else begin
                    j_d = '0;
                    // Counters park at zero on the way to DONE so they never pass DIM-2
                    if (p_q == C_LAST) begin
                        p_d     = '0;
                        state_d = DONE;
                    end else begin
                        p_d = p_q + CW'(1);
                    end
`ifdef BUBBLE_SORT_SEQ_EARLY_EXIT_EN
                    swf_d = 1'b0;
                    if (!w_pass_swapped) begin
                        p_d     = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, register file and counters; synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mem_q   <= '0;
            p_q     <= '0;
            j_q     <= '0;
`ifdef BUBBLE_SORT_SEQ_EARLY_EXIT_EN
            swf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            p_q     <= p_d;
            j_q     <= j_d;
`ifdef BUBBLE_SORT_SEQ_EARLY_EXIT_EN
            swf_q   <= swf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SORT);
    assign out_data  = mem_q;

endmodule
`default_nettype wire

// File: tb/tb_bubble_sort_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bubble_sort_seq
//  Description : Self-checking bench for bubble_sort_seq (DIM=4, WIDTH=8)
//                with a sort/latency reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bubble_sort_seq;
    import bubble_sort_pkg::*;

    localparam int DIM   = 4;
    localparam int WIDTH = 8;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b0;
    logic                 in_valid  = 1'b0;
    logic                 out_ready = 1'b0;
    logic [DIM*WIDTH-1:0] in_data   = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic                 busy;
    logic [DIM*WIDTH-1:0] out_data;

    int total = 0;
    int bad   = 0;

    bubble_sort_seq #(
        .DIM       (DIM),
        .WIDTH     (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: ascending sort of the unpacked elements
    function automatic logic [DIM*WIDTH-1:0] ref_sort(input logic [DIM*WIDTH-1:0] d);
        logic [WIDTH-1:0]     q[$];
        logic [DIM*WIDTH-1:0] r;
        for (int k = 0; k < DIM; k++) q.push_back(d[k*WIDTH +: WIDTH]);
        q.sort();
        r = '0;
        for (int k = 0; k < DIM; k++) r[k*WIDTH +: WIDTH] = q[k];
        return r;
    endfunction

    // Reference: compare cycles from acceptance to result
    function automatic int ref_latency(input logic [DIM*WIDTH-1:0] d);
`ifdef BUBBLE_SORT_SEQ_EARLY_EXIT_EN
        // Passes that swap = largest count of strictly greater elements left of
        // any element; one further clean pass is needed unless passes run out.
        int dmax = 0;
        int passes;
        int cmp = 0;
        for (int i = 0; i < DIM; i++) begin
            int cnt = 0;
            for (int k = 0; k < i; k++)
                if (d[k*WIDTH +: WIDTH] > d[i*WIDTH +: WIDTH]) cnt++;
            if (cnt > dmax) dmax = cnt;
        end
        passes = (dmax + 1 < DIM - 1) ? dmax + 1 : DIM - 1;
        for (int k = 0; k < passes; k++) cmp += DIM - 1 - k;
        return cmp;
`else
        return n_compares(DIM);
`endif
    endfunction

    task automatic do_sort(input logic [DIM*WIDTH-1:0] d, input string tag, input int hold);
        int                   cyc;
        logic [DIM*WIDTH-1:0] exp;
        exp = ref_sort(d);
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            check({tag, ".busy"}, 64'(busy), 64'd1);
            check({tag, ".in_ready_sort"}, 64'(in_ready), 64'd0);
            @(posedge clk); #1; cyc++;
        end
        check({tag, ".latency"}, 64'(cyc), 64'(ref_latency(d)));
        check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        check({tag, ".busy_done"}, 64'(busy), 64'd0);
        check({tag, ".out_data"}, 64'(out_data), 64'(exp));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            @(posedge clk); #1;
            check({tag, ".bp_data"}, 64'(out_data), 64'(exp));
            check({tag, ".bp_in_ready"}, 64'(in_ready), 64'd0);
            check({tag, ".bp_valid"}, 64'(out_valid), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".valid_after"}, 64'(out_valid), 64'd0);
        check({tag, ".ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.out_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;

        // Directed arrays (packed as {e3,e2,e1,e0})
        do_sort(32'h20301040, "basic", 0);
        check("basic.const", 64'(ref_sort(32'h20301040)), 64'h40302010);
        do_sort(32'h000180FF, "reversed", 0);
        do_sort(32'h05030505, "dups", 0);
        do_sort(32'h04030201, "sorted", 0);

        // Backpressure with in_valid asserted, then a second array
        do_sort(32'h11AA0033, "bp", 5);
        do_sort(32'h7F017F00, "after_bp", 0);

        // Reset during the third compare
        in_valid = 1'b1;
        in_data  = 32'h99887766;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort.busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort.in_ready", 64'(in_ready), 64'd1);
        check("abort.out_valid", 64'(out_valid), 64'd0);
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.out_data", 64'(out_data), 64'd0);
        do_sort(32'h01020304, "post_abort", 0);

        // Randomized arrays, half of them drawn from a small value range to force ties
        for (int n = 0; n < 24; n++) begin
            logic [DIM*WIDTH-1:0] d;
            d = $urandom;
            if (n % 2 == 1)
                for (int k = 0; k < DIM; k++) d[k*WIDTH +: WIDTH] = 8'($urandom_range(0, 3));
            do_sort(d, "rand", (n % 3 == 0) ? 2 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
